// File: rtl/axi2fifo_asyn.sv
// axi2fifo_asyn: repacks 256-bit AXI-Stream packets into 202-bit memory words
// (header + 192-bit payload words) via a multi-write FIFO drained one word per cycle.
module axi2fifo_asyn #(
  parameter int FIFO_DEPTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tvalid,
  output logic         tready,
  input  logic [255:0] tdata,
  input  logic [31:0]  tstrb,
  input  logic [127:0] tuser,
  input  logic         tlast,
  output logic [201:0] dout,
  output logic         dout_valid,
  output logic [4:0]   oq,
  output logic [2:0]   queue_id
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  function automatic logic [201:0] mk_word(logic [191:0] payload, logic [4:0] cnt,
                                           logic [2:0] typ, logic last);
    return {payload, cnt, typ, last, 1'b0};
  endfunction

  // ports = tuser[31:24]; even bits map straight through, odd bits fold into oq[4]
  function automatic logic [4:0] oq_of(logic [7:0] ports);
    return {ports[1] | ports[3] | ports[5] | ports[7], ports[6], ports[4], ports[2], ports[0]};
  endfunction

  function automatic logic [2:0] lowest_set(logic [4:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  logic [1:0]    phase;
  logic          first;
  logic [127:0]  keep;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [201:0]  mem [FIFO_DEPTH];
  logic [201:0]  hdr;
  logic [201:0]  d0;
  logic [201:0]  d1;
  logic [1:0]    nd;
  logic [201:0]  wq [3];
  logic [1:0]    n_wr;
  logic          accept;
  logic          pop;
  logic [201:0]  head;
  logic          unused_strb;

  assign unused_strb = ^tstrb;
  assign tready = !reset && (count <= CW'(FIFO_DEPTH - 3));
  assign accept = tvalid && tready;
  assign pop    = (count != '0);
  assign head   = mem[rd_ptr];
  assign hdr    = mk_word({64'd0, tuser}, 5'd16, 3'd0, 1'b0);

  // Stage 0: slice the beat into up to two data words for the current phase
  always_comb begin
    d0 = '0;
    d1 = '0;
    nd = 2'd0;
    case (phase)
      2'd0: begin
        d0 = mk_word(tdata[255:64], 5'd24, 3'd1, 1'b0);
        d1 = mk_word({tdata[63:0], 128'd0}, 5'd8, 3'd3, 1'b1);
        nd = tlast ? 2'd2 : 2'd1;
      end
      2'd1: begin
        d0 = mk_word({keep[127:64], tdata[255:128]}, 5'd24, 3'd1, 1'b0);
        d1 = mk_word({tdata[127:0], 64'd0}, 5'd16, 3'd2, 1'b1);
        nd = tlast ? 2'd2 : 2'd1;
      end
      default: begin
        d0 = mk_word({keep, tdata[255:192]}, 5'd24, 3'd1, 1'b0);
        d1 = mk_word(tdata[191:0], 5'd24, tlast ? 3'd4 : 3'd1, tlast);
        nd = 2'd2;
      end
    endcase
  end

  // A packet start is always in phase 0, so the header simply shifts the data words up one slot
  always_comb begin
    wq[0] = first ? hdr : d0;
    wq[1] = first ? d0 : d1;
    wq[2] = d1;
    n_wr  = accept ? (nd + {1'b0, first}) : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      if (phase == 2'd0) keep[127:64] <= tdata[63:0];
      else if (phase == 2'd1) keep <= tdata[127:0];
    end
  end

  // Stage 1: FIFO storage, up to three writes in stream order
  always_ff @(posedge clk) begin
    if (n_wr != 2'd0) mem[wr_ptr] <= wq[0];
    if (n_wr >= 2'd2) mem[wr_ptr + AW'(1)] <= wq[1];
    if (n_wr == 2'd3) mem[wr_ptr + AW'(2)] <= wq[2];
  end

  // Stage 2: control state and the registered output word
  always_ff @(posedge clk) begin
    if (reset) begin
      phase      <= 2'd0;
      first      <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout_valid <= 1'b0;
      dout       <= '0;
      oq         <= '0;
      queue_id   <= '0;
    end else begin
      if (accept) begin
        first <= tlast;
        phase <= (tlast || phase == 2'd2) ? 2'd0 : phase + 2'd1;
      end
      wr_ptr     <= wr_ptr + AW'(n_wr);
      rd_ptr     <= rd_ptr + AW'(pop);
      count      <= count + CW'(n_wr) - CW'(pop);
      dout_valid <= pop;
      if (pop) begin
        dout <= head;
        if (head[4:2] == 3'd0) begin
          oq       <= oq_of(head[41:34]);
          queue_id <= lowest_set(oq_of(head[41:34]));
        end
      end
    end
  end
endmodule

// File: tb/tb_axi2fifo_asyn.sv
// Scoreboard bench for axi2fifo_asyn: expected words are cut from the packet's MSB-first
// bitstream in 192-bit chunks and checked by an independent output monitor.
module tb_axi2fifo_asyn;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         tvalid;
  logic         tready;
  logic [255:0] tdata;
  logic [31:0]  tstrb;
  logic [127:0] tuser;
  logic         tlast;
  logic [201:0] dout;
  logic         dout_valid;
  logic [4:0]   oq;
  logic [2:0]   queue_id;

  axi2fifo_asyn #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .tvalid(tvalid), .tready(tready), .tdata(tdata),
    .tstrb(tstrb), .tuser(tuser), .tlast(tlast), .dout(dout), .dout_valid(dout_valid),
    .oq(oq), .queue_id(queue_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [201:0] w;
    logic [4:0]   oq;
    logic [2:0]   qid;
  } exp_t;

  exp_t         sb[$];
  logic [255:0] pb[$];
  int           vectors = 0;
  int           errors = 0;
  int           written = 0;
  int           popped = 0;
  int           type_cnt[8];
  logic [4:0]   cur_oq;
  logic [2:0]   cur_qid;

  task automatic check(string name, logic [201:0] act, logic [201:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic stream_bit(int p);
    int b;
    b = p / 256;
    if (b >= pb.size()) return 1'b0;
    return pb[b][255 - (p % 256)];
  endfunction

  function automatic logic [191:0] chunk(int k);
    logic [191:0] c;
    c = '0;
    for (int b = 0; b < 192; b++) c[191-b] = stream_bit(192 * k + b);
    return c;
  endfunction

  task automatic push_word(logic [191:0] payload, logic [4:0] cnt, logic [2:0] typ, logic last);
    exp_t e;
    e.w   = {payload, cnt, typ, last, 1'b0};
    e.oq  = cur_oq;
    e.qid = cur_qid;
    sb.push_back(e);
    written++;
  endtask

  // Expected words released by accepted beat i (pb already holds beats 0..i)
  task automatic account(int i, logic last, logic [127:0] user);
    int lo, hi, rem;
    lo  = (256 * i) / 192;
    hi  = (256 * (i + 1)) / 192;
    rem = (256 * (i + 1)) % 192;
    if (i == 0) push_word({64'd0, user}, 5'd16, 3'd0, 1'b0);
    for (int k = lo; k < hi; k++) begin
      if (last && rem == 0 && k == hi - 1) push_word(chunk(k), 5'd24, 3'd4, 1'b1);
      else push_word(chunk(k), 5'd24, 3'd1, 1'b0);
    end
    if (last && rem == 64)  push_word(chunk(hi), 5'd8, 3'd3, 1'b1);
    if (last && rem == 128) push_word(chunk(hi), 5'd16, 3'd2, 1'b1);
  endtask

  task automatic send_pkt(int n, logic [7:0] ports, logic [255:0] base, logic [4:0] eoq,
                          logic [2:0] eqid, bit hold, int abort_at);
    logic [127:0] user;
    user = {64'h0123_4567_89AB_CDEF, 32'h5A5A_C3C3, ports, 24'h00BEEF};
    pb.delete();
    cur_oq  = eoq;
    cur_qid = eqid;
    for (int i = 0; i < n; i++) begin
      bit acc;
      int guard;
      guard  = 0;
      tvalid = 1'b1;
      tdata  = base + 256'(i);
      tuser  = (i == 0) ? user : ~user;
      tlast  = (i == n - 1);
      do begin
        @(negedge clk);
        acc = tready;
        @(posedge clk);
        #1;
        guard++;
      end while (!acc && guard < 200);
      if (!acc) begin
        vectors++;
        errors++;
        $display("FAIL beat_timeout: beat %0d not accepted, expected within 200 cycles", i);
        tvalid = 1'b0;
        return;
      end
      pb.push_back(tdata);
      account(i, tlast, user);
      if (abort_at == i + 1) begin
        tvalid = 1'b0;
        return;
      end
    end
    if (!hold) tvalid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 500) begin
      @(posedge clk);
      g++;
    end
    #1;
    check("drain_outstanding", 202'(sb.size()), 202'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_types(int t0, int t1, int t2, int t3, int t4);
    check("type0_count", 202'(type_cnt[0]), 202'(t0));
    check("type1_count", 202'(type_cnt[1]), 202'(t1));
    check("type2_count", 202'(type_cnt[2]), 202'(t2));
    check("type3_count", 202'(type_cnt[3]), 202'(t3));
    check("type4_count", 202'(type_cnt[4]), 202'(t4));
  endtask

  task automatic new_test();
    foreach (type_cnt[i]) type_cnt[i] = 0;
    written = 0;
    popped  = 0;
  endtask

  // Output monitor: every presented word is compared against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) continue;
      if (dout_valid === 1'b1) begin
        popped++;
        type_cnt[dout[4:2]]++;
        if (sb.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_word: got %h expected no word", dout);
        end else begin
          e = sb.pop_front();
          check("dout", dout, e.w);
          check("oq", 202'(oq), 202'(e.oq));
          check("queue_id", 202'(queue_id), 202'(e.qid));
        end
      end
      if (tvalid === 1'b1)
        check("tready", 202'(tready), 202'((DEPTH - (written - popped)) >= 3));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    tvalid = 1'b0;
    tdata  = '0;
    tstrb  = '1;
    tuser  = '0;
    tlast  = 1'b0;
    foreach (type_cnt[i]) type_cnt[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tready", 202'(tready), 202'd0);
    check("rst_dout_valid", 202'(dout_valid), 202'd0);
    check("rst_dout", dout, 202'd0);
    check("rst_oq", 202'(oq), 202'd0);
    check("rst_queue_id", 202'(queue_id), 202'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1-beat packet, ports 0xAF -> oq 10011, queue 0; also first-word latency
    new_test();
    send_pkt(1, 8'hAF, 256'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F_01234567_89ABCDEF_FEDCBA98_76543210,
             5'b10011, 3'd0, 1'b0, 0);
    @(negedge clk);
    check("latency_1cyc_idle", 202'(dout_valid), 202'd0);
    @(negedge clk);
    check("latency_2cyc_valid", 202'(dout_valid), 202'd1);
    check("latency_2cyc_header", 202'(dout[4:2]), 202'd0);
    @(posedge clk);
    #1;
    drain();
    check_types(1, 1, 0, 1, 0);

    // 2-beat packet, ports 0x04 -> oq 00010, queue 1
    new_test();
    send_pkt(2, 8'h04, 256'hAAAA5555_CCCC3333_0F0F0F0F_12345678_9ABCDEF0_DEADBEEF_CAFEF00D_00000100,
             5'b00010, 3'd1, 1'b0, 0);
    drain();
    check_types(1, 2, 1, 0, 0);

    // 3-beat packet, ports 0x10 -> oq 00100, queue 2
    new_test();
    send_pkt(3, 8'h10, 256'h11112222_33334444_55556666_77778888_9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0000,
             5'b00100, 3'd2, 1'b0, 0);
    drain();
    check_types(1, 3, 0, 0, 1);

    // 31-beat incrementing packet from 50, ports 0xEA -> oq 11000, queue 3
    new_test();
    send_pkt(31, 8'hEA, 256'd50, 5'b11000, 3'd3, 1'b0, 0);
    drain();
    check_types(1, 41, 0, 1, 0);

    // Two back-to-back 31-beat packets with tvalid held throughout
    new_test();
    send_pkt(31, 8'h02, 256'h8000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_1000,
             5'b10000, 3'd4, 1'b1, 0);
    send_pkt(31, 8'h00, 256'h0000_7777_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_2000,
             5'b00000, 3'd0, 1'b0, 0);
    drain();
    check("b2b_word_total", 202'(popped), 202'd86);
    check_types(2, 82, 0, 2, 0);

    // Reset after 10 beats of a packet, then a fresh 2-beat packet
    new_test();
    send_pkt(31, 8'h55, 256'h1357_9BDF_2468_ACE0_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0300,
             5'b01111, 3'd0, 1'b0, 10);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_tready", 202'(tready), 202'd0);
    check("midrst_dout_valid", 202'(dout_valid), 202'd0);
    check("midrst_dout", dout, 202'd0);
    check("midrst_oq", 202'(oq), 202'd0);
    check("midrst_queue_id", 202'(queue_id), 202'd0);
    sb.delete();
    new_test();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    send_pkt(2, 8'h40, 256'h0BAD_F00D_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0400,
             5'b01000, 3'd3, 1'b0, 0);
    drain();
    check("post_reset_word_total", 202'(popped), 202'd4);
    check_types(1, 2, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
